breakout_game_ctrl: RTL and testbench

Parametrised game-flow controller for the breakout design; replaces fixed-size, single-level game control in the integration layer. Owns the pixel clock-enable, the block bitmap, lives, level progression, score and the serve/play/lose/win sequencing. Sits between the button/collision logic (hit and ball-lost events) and the ball/display logic (block bitmap, ball hold, speed, status).

---
 rtl/breakout_game_ctrl_pkg.sv | 25 ++
 rtl/breakout_game_ctrl_game_frame_timer.sv | 29 ++
 rtl/breakout_game_ctrl.sv | 157 +++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_game_ctrl_pkg.sv
// Shared definitions for the breakout game-flow controller: state codes,
// per-row score weight and block bitmap indexing.
package breakout_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_LOST      = 3'd4,
        ST_CLEAR     = 3'd5,
        ST_GAME_OVER = 3'd6,
        ST_WIN       = 3'd7
    } state_t;

    // Top rows are harder to reach, so they score more.
    function automatic int score_weight(input int n_rows, input int row);
        return n_rows - row;
    endfunction

    function automatic int blk_idx(input int row, input int col, input int n_cols);
        return row * n_cols + col;
    endfunction

endpackage

// File: rtl/breakout_game_ctrl_game_frame_timer.sv
// Counts frame pulses while enabled; done fires on the PAUSE_FRAMES-th pulse.
module game_frame_timer
    import breakout_game_ctrl_pkg::*;
#(
    parameter int PAUSE_FRAMES = 60
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    input  logic frame_pulse,
    output logic done
);

    localparam int CNT_W = $clog2(PAUSE_FRAMES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            cnt <= '0;
        end else if (enable && frame_pulse) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = enable && frame_pulse && (cnt == CNT_W'(PAUSE_FRAMES - 1));

endmodule

// File: rtl/breakout_game_ctrl.sv
// Game-flow controller for breakout: pixel clock enable, block bitmap,
// lives, levels, score and serve/play/lose/win sequencing.
module breakout_game_ctrl
    import breakout_game_ctrl_pkg::*;
#(
    parameter int N_ROWS       = 3,
    parameter int N_COLS       = 8,
    parameter int LIVES        = 3,
    parameter int N_LEVELS     = 4,
    parameter int SCORE_W      = 12,
    parameter int PAUSE_FRAMES = 60,
    parameter int PXL_DIV      = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       frame_pulse,
    input  logic                       hit_valid,
    input  logic [2:0]                 hit_row,
    input  logic [3:0]                 hit_col,
    input  logic                       ball_lost,
    output logic                       pxl_ce,
    output logic [N_ROWS*N_COLS-1:0]   block_status,
    output logic                       ball_hold,
    output logic [1:0]                 speed,
    output logic [2:0]                 lives,
    output logic [2:0]                 level,
    output logic [SCORE_W-1:0]         score,
    output logic [2:0]                 state,
    output logic                       win,
    output logic                       lose
);

    localparam int N_BLK = N_ROWS * N_COLS;
    localparam int IDX_W = (N_BLK > 1) ? $clog2(N_BLK) : 1;
    localparam int DIV_W = (PXL_DIV > 1) ? $clog2(PXL_DIV) : 1;

    state_t             state_q, state_next;
    logic [DIV_W-1:0]   div_cnt, div_next;
    logic [N_BLK-1:0]   hit_mask, blocks_next;
    logic               hit_in_range, hit_ok;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [2:0]         lives_next, level_next;
    logic               timer_clear, timer_en, timer_done;

    game_frame_timer #(
        .PAUSE_FRAMES (PAUSE_FRAMES)
    ) u_frame_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (timer_clear),
        .enable      (timer_en),
        .frame_pulse (frame_pulse),
        .done        (timer_done)
    );

    assign timer_en = (state_q == ST_LOST) || (state_q == ST_CLEAR);
    assign div_next = (div_cnt == DIV_W'(PXL_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);

    always_comb begin
        hit_mask     = '0;
        hit_in_range = (int'(hit_row) < N_ROWS) && (int'(hit_col) < N_COLS);
        if (hit_in_range) begin
            hit_mask[IDX_W'(blk_idx(int'(hit_row), int'(hit_col), N_COLS))] = 1'b1;
        end
    end

    // Out-of-range rows can give a meaningless weight, but hit_ok masks them.
    assign hit_ok    = hit_valid && (|(block_status & hit_mask));
    assign score_sum = {1'b0, score} + (SCORE_W+1)'(score_weight(N_ROWS, int'(hit_row)));

    always_comb begin
        state_next  = state_q;
        blocks_next = block_status;
        lives_next  = lives;
        level_next  = level;
        score_next  = score;
        timer_clear = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_next = ST_SERVE;
            ST_SERVE: if (start) state_next = ST_PLAY;
            ST_PLAY: begin
                if (hit_ok) begin
                    blocks_next = block_status & ~hit_mask;
                    score_next  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                end
                // Clearing the last block beats a simultaneous ball loss.
                if (hit_ok && (blocks_next == '0)) begin
                    state_next  = ST_CLEAR;
                    timer_clear = 1'b1;
                end else if (ball_lost) begin
                    state_next  = ST_LOST;
                    lives_next  = lives - 3'd1;
                    timer_clear = 1'b1;
                end else if (start) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: if (start) state_next = ST_PLAY;
            ST_LOST: begin
                if (timer_done) state_next = (lives != 3'd0) ? ST_SERVE : ST_GAME_OVER;
            end
            ST_CLEAR: begin
                if (timer_done) begin
                    if (int'(level) == N_LEVELS - 1) begin
                        state_next = ST_WIN;
                    end else begin
                        level_next  = level + 3'd1;
                        blocks_next = '1;
                        state_next  = ST_SERVE;
                    end
                end
            end
            ST_GAME_OVER, ST_WIN: begin
                if (start) begin
                    state_next  = ST_SERVE;
                    lives_next  = 3'(LIVES);
                    level_next  = 3'd0;
                    score_next  = '0;
                    blocks_next = '1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            div_cnt      <= '0;
            pxl_ce       <= 1'b0;
            block_status <= '1;
            ball_hold    <= 1'b1;
            lives        <= 3'(LIVES);
            level        <= 3'd0;
            score        <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            state_q      <= state_next;
            div_cnt      <= div_next;
            pxl_ce       <= (div_next == DIV_W'(PXL_DIV - 1));
            block_status <= blocks_next;
            ball_hold    <= (state_next != ST_PLAY);
            lives        <= lives_next;
            level        <= level_next;
            score        <= score_next;
            win          <= (state_next == ST_WIN);
            lose         <= (state_next == ST_GAME_OVER);
        end
    end

    assign state = state_q;
    assign speed = (level >= 3'd3) ? 2'd3 : level[1:0];

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Self-checking bench for breakout_game_ctrl against an array-based game model.
module tb_breakout_game_ctrl;

    localparam int NR = 3, NC = 8, LV = 3, NL = 4, SW = 12, PF = 60, PD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, frame_pulse, hit_valid, ball_lost;
    logic [2:0] hit_row;
    logic [3:0] hit_col;
    logic pxl_ce, ball_hold, win, lose;
    logic [NR*NC-1:0] block_status;
    logic [1:0] speed;
    logic [2:0] lives, level, state;
    logic [SW-1:0] score;

    logic reset_n_b, start_b, hit_valid_b;
    logic [2:0] hit_row_b;
    logic [3:0] hit_col_b;
    logic pxl_ce_b, ball_hold_b, win_b, lose_b;
    logic [23:0] block_status_b;
    logic [1:0] speed_b;
    logic [2:0] lives_b, level_b, state_b;
    logic [3:0] score_b;

    breakout_game_ctrl #(
        .N_ROWS(NR), .N_COLS(NC), .LIVES(LV), .N_LEVELS(NL),
        .SCORE_W(SW), .PAUSE_FRAMES(PF), .PXL_DIV(PD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .frame_pulse(frame_pulse),
        .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
        .ball_lost(ball_lost), .pxl_ce(pxl_ce), .block_status(block_status),
        .ball_hold(ball_hold), .speed(speed), .lives(lives), .level(level),
        .score(score), .state(state), .win(win), .lose(lose)
    );

    breakout_game_ctrl #(
        .N_ROWS(3), .N_COLS(8), .LIVES(3), .N_LEVELS(4),
        .SCORE_W(4), .PAUSE_FRAMES(2), .PXL_DIV(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n_b), .start(start_b), .frame_pulse(1'b0),
        .hit_valid(hit_valid_b), .hit_row(hit_row_b), .hit_col(hit_col_b),
        .ball_lost(1'b0), .pxl_ce(pxl_ce_b), .block_status(block_status_b),
        .ball_hold(ball_hold_b), .speed(speed_b), .lives(lives_b), .level(level_b),
        .score(score_b), .state(state_b), .win(win_b), .lose(lose_b)
    );

    int errors = 0;
    int checks = 0;

    // Game model: 0 idle, 1 serve, 2 play, 3 pause, 4 lost, 5 clear, 6 game over, 7 win
    int m_state, m_lives, m_level, m_score, m_frames, m_cyc;
    bit m_blk[NR][NC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int blocks_left();
        int n = 0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                n += int'(m_blk[r][c]);
        return n;
    endfunction

    task automatic fill_blocks();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                m_blk[r][c] = 1'b1;
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = LV; m_level = 0; m_score = 0; m_frames = 0; m_cyc = 0;
        fill_blocks();
    endtask

    task automatic model_tick(input bit st, input bit fp, input bit hv,
                              input int hr, input int hc, input bit bl);
        bit last;
        m_cyc++;
        case (m_state)
            0: if (st) m_state = 1;
            1: if (st) m_state = 2;
            2: begin
                last = 1'b0;
                if (hv && hr < NR && hc < NC && m_blk[hr][hc]) begin
                    m_blk[hr][hc] = 1'b0;
                    m_score = m_score + (NR - hr);
                    if (m_score > (1 << SW) - 1) m_score = (1 << SW) - 1;
                    last = (blocks_left() == 0);
                end
                if (last) begin
                    m_state = 5; m_frames = 0;
                end else if (bl) begin
                    m_state = 4; m_frames = 0; m_lives--;
                end else if (st) begin
                    m_state = 3;
                end
            end
            3: if (st) m_state = 2;
            4, 5: if (fp) begin
                m_frames++;
                if (m_frames == PF) begin
                    if (m_state == 4) begin
                        m_state = (m_lives > 0) ? 1 : 6;
                    end else if (m_level == NL - 1) begin
                        m_state = 7;
                    end else begin
                        m_level++; fill_blocks(); m_state = 1;
                    end
                end
            end
            default: if (st) begin
                m_state = 1; m_lives = LV; m_level = 0; m_score = 0; fill_blocks();
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        logic [NR*NC-1:0] eb;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                eb[r*NC+c] = m_blk[r][c];
        check({tag, ".state"}, 32'(state), m_state);
        check({tag, ".ball_hold"}, 32'(ball_hold), (m_state != 2) ? 1 : 0);
        check({tag, ".blocks"}, 32'(block_status), 32'(eb));
        check({tag, ".lives"}, 32'(lives), m_lives);
        check({tag, ".level"}, 32'(level), m_level);
        check({tag, ".speed"}, 32'(speed), (m_level > 3) ? 3 : m_level);
        check({tag, ".score"}, 32'(score), m_score);
        check({tag, ".win"}, 32'(win), (m_state == 7) ? 1 : 0);
        check({tag, ".lose"}, 32'(lose), (m_state == 6) ? 1 : 0);
        check({tag, ".pxl_ce"}, 32'(pxl_ce), (m_cyc > 0 && (m_cyc % PD) == PD - 1) ? 1 : 0);
    endtask

    task automatic step(input bit st, input bit fp, input bit hv, input int hr,
                        input int hc, input bit bl, input string tag);
        start = st; frame_pulse = fp; hit_valid = hv;
        hit_row = 3'(hr); hit_col = 4'(hc); ball_lost = bl;
        model_tick(st, fp, hv, hr, hc, bl);
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 0; frame_pulse = 0; hit_valid = 0; hit_row = 0; hit_col = 0; ball_lost = 0;
        model_reset();
        @(posedge clk); #1;
        check_all("reset");
        reset_n = 1'b1;
    endtask

    task automatic frames(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, tag);
    endtask

    initial begin
        reset_n_b = 0; start_b = 0; hit_valid_b = 0; hit_row_b = 0; hit_col_b = 0;

        do_reset();
        do_reset();

        // Basic bring-up and hit rules
        step(1, 0, 0, 0, 0, 0, "start_serve");
        check("serve_state", 32'(state), 1);
        step(1, 0, 0, 0, 0, 0, "start_play");
        check("play_hold", 32'(ball_hold), 0);
        check("play_bitmap", 32'(block_status), 32'h00FF_FFFF);
        step(0, 0, 1, 0, 5, 0, "hit_0_5");
        check("hit_score", 32'(score), 3);
        step(0, 0, 1, 0, 5, 0, "hit_0_5_again");
        check("rehit_score", 32'(score), 3);
        step(0, 0, 1, 3, 8, 0, "hit_out_of_range");
        step(1, 0, 0, 0, 0, 0, "pause");
        step(0, 0, 1, 1, 1, 0, "hit_in_pause");
        step(1, 0, 0, 0, 0, 0, "resume");

        // Random play against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 9)), $urandom_range(0, 59) == 0, "random");
        end

        // Mid-game reset, then lose all balls
        do_reset();
        step(1, 0, 0, 0, 0, 0, "lose_serve");
        step(0, 0, 1, 0, 0, 0, "hit_in_serve");
        check("serve_hit_ignored", 32'(block_status), 32'h00FF_FFFF);
        step(1, 0, 0, 0, 0, 0, "lose_play");
        step(1, 0, 0, 0, 0, 1, "lost_with_start");
        check("lost1_state", 32'(state), 4);
        check("lost1_lives", 32'(lives), 2);
        step(1, 1, 0, 0, 0, 0, "start_in_lost");
        frames(PF - 1, "lost1_wait");
        check("lost1_serve", 32'(state), 1);
        step(1, 0, 0, 0, 0, 0, "lose_play2");
        step(0, 0, 0, 0, 0, 1, "lost2");
        frames(PF, "lost2_wait");
        check("lost2_lives", 32'(lives), 1);
        step(1, 0, 0, 0, 0, 0, "lose_play3");
        step(0, 0, 0, 0, 0, 1, "lost3");
        check("lost3_lives", 32'(lives), 0);
        frames(PF, "lost3_wait");
        check("game_over_state", 32'(state), 6);
        check("game_over_lose", 32'(lose), 1);
        step(1, 0, 0, 0, 0, 0, "restart");
        check("restart_score", 32'(score), 0);
        check("restart_lives", 32'(lives), 3);

        // Clear every level, last hit coincident with ball loss
        do_reset();
        step(1, 0, 0, 0, 0, 0, "clr_serve");
        for (int lv = 0; lv < NL; lv++) begin
            step(1, 0, 0, 0, 0, 0, "clr_play");
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++)
                    step(0, 0, 1, r, c, (r == NR - 1 && c == NC - 1), "clr_hit");
            check("clear_state", 32'(state), 5);
            check("clear_lives", 32'(lives), 3);
            step(0, 0, 0, 0, 0, 0, "clr_gap");
            frames(PF, "clr_wait");
            if (lv < NL - 1) begin
                check("next_level", 32'(level), lv + 1);
                check("next_bitmap", 32'(block_status), 32'h00FF_FFFF);
            end
        end
        check("win_state", 32'(state), 7);
        check("win_flag", 32'(win), 1);
        step(1, 0, 0, 0, 0, 0, "win_restart");

        // Second instance: PXL_DIV=4 and 4-bit saturating score
        reset_n_b = 0;
        @(posedge clk); #1;
        check("b_reset_pxl", 32'(pxl_ce_b), 0);
        reset_n_b = 1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            check("b_pxl_ce", 32'(pxl_ce_b), (k % 4 == 3) ? 1 : 0);
        end
        start_b = 1;
        repeat (2) @(posedge clk);
        #1; start_b = 0;
        check("b_play", 32'(state_b), 2);
        for (int i = 0; i < 6; i++) begin
            hit_valid_b = 1; hit_row_b = 3'd0; hit_col_b = 4'(i);
            @(posedge clk); #1;
            check("b_score", 32'(score_b), (3 * (i + 1) > 15) ? 15 : 3 * (i + 1));
        end
        hit_row_b = 3'd2; hit_col_b = 4'd0;
        @(posedge clk); #1;
        hit_valid_b = 0;
        check("b_score_hold", 32'(score_b), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
